led_pattern_driver: RTL and testbench

Parametrised LED animation engine for the board LED bank. It is the successor to the single-speed binary-count LED driver.
- Two raw push-buttons are synchronised and debounced on-chip.
- One button steps through SPEED_N tick rates derived from CLK_HZ.
- The other button selects one of four patterns: binary count, chase, bounce, blink.
- Drives active-low LEDs directly and exports the current speed/mode for status display.

---
 rtl/led_pattern_driver.sv | 188 ++++++++++++++++++
 tb/tb_led_pattern_driver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// LED animation engine: two debounced buttons select the step rate and one of four
// patterns (count, chase, bounce, blink) shown on an active-low LED bank.

module led_pattern_driver_btn #(
   parameter int unsigned DEB_CYC = 270000
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic          deb_prev_q;
   logic [DW-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
      end
   end

   // The window restarts whenever the synchronised input agrees with deb again.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_MAX) begin
         deb_d = ~deb_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DW'(1);
      end
   end

   assign pulse_o = deb_q & ~deb_prev_q;

endmodule

// state (mode_q) | meaning
// MODE_COUNT     | binary count 0..COUNT_MAX, then wrap to 0
// MODE_CHASE     | single lit LED rotating left
// MODE_BOUNCE    | single lit LED sweeping left and right
// MODE_BLINK     | all LEDs toggling together
module led_pattern_driver #(
   parameter int unsigned CLK_HZ    = 27000000,
   parameter int unsigned LED_W     = 6,
   parameter int unsigned SPEED_N   = 3,
   parameter int unsigned COUNT_MAX = 60,
   parameter int unsigned DEB_CYC   = 270000,
   localparam int unsigned SW = (SPEED_N > 1) ? $clog2(SPEED_N) : 1
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             iBtnSpeed,
   input  logic             iBtnMode,
   output logic [LED_W-1:0] oLED,
   output logic [SW-1:0]    oSpeed,
   output logic [1:0]       oMode
);

   localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [SW-1:0]    SPEED_MAX = SW'(SPEED_N - 1);
   localparam logic [LED_W-1:0] PAT_WRAP  = LED_W'(COUNT_MAX);

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   logic             speed_pulse, mode_pulse;
   logic             step;
   logic [TW-1:0]    tick_max;
   logic [LED_W-1:0] pat_shl, pat_shr;

   mode_e            mode_q, mode_d;
   dir_e             dir_q, dir_d;
   logic [SW-1:0]    speed_q, speed_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [LED_W-1:0] pat_q, pat_d;

   led_pattern_driver_btn #(.DEB_CYC(DEB_CYC)) u_btn_speed (
      .CLK    (CLK),
      .RESETn (RESETn),
      .btn_i  (iBtnSpeed),
      .pulse_o(speed_pulse)
   );

   led_pattern_driver_btn #(.DEB_CYC(DEB_CYC)) u_btn_mode (
      .CLK    (CLK),
      .RESETn (RESETn),
      .btn_i  (iBtnMode),
      .pulse_o(mode_pulse)
   );

   function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
      logic [LED_W-1:0] p;
      p = '0;
      if (m == MODE_CHASE || m == MODE_BOUNCE) p = LED_W'(1);
      return p;
   endfunction

   // Each speed level halves the step period.
   assign tick_max = TW'((CLK_HZ >> speed_q) - 1);
   assign step     = (tick_q == tick_max);
   assign pat_shl  = pat_q << 1;
   assign pat_shr  = pat_q >> 1;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         mode_q  <= MODE_COUNT;
         dir_q   <= DIR_LEFT;
         speed_q <= '0;
         tick_q  <= '0;
         pat_q   <= '0;
      end else begin
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         speed_q <= speed_d;
         tick_q  <= tick_d;
         pat_q   <= pat_d;
      end
   end

   // Button pulses take priority over a step landing in the same cycle.
   always_comb begin
      mode_d  = mode_q;
      dir_d   = dir_q;
      speed_d = speed_q;
      tick_d  = tick_q + TW'(1);
      pat_d   = pat_q;
      if (speed_pulse || mode_pulse) begin
         tick_d = '0;
         if (speed_pulse) begin
            speed_d = (speed_q == SPEED_MAX) ? '0 : speed_q + SW'(1);
         end
         if (mode_pulse) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pat_d  = init_pattern(mode_d);
            dir_d  = DIR_LEFT;
         end
      end else if (step) begin
         tick_d = '0;
         case (mode_q)
            MODE_COUNT: pat_d = (pat_q == PAT_WRAP) ? '0 : pat_q + LED_W'(1);
            MODE_CHASE: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            MODE_BOUNCE: begin
               if (dir_q == DIR_LEFT) begin
                  pat_d = pat_shl;
                  if (pat_shl[LED_W-1]) dir_d = DIR_RIGHT;
               end else begin
                  pat_d = pat_shr;
                  if (pat_shr[0]) dir_d = DIR_LEFT;
               end
            end
            MODE_BLINK: pat_d = ~pat_q;
            default: pat_d = '0;
         endcase
      end
   end

   assign oLED   = ~pat_q;
   assign oSpeed = speed_q;
   assign oMode  = mode_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with a small clock and debounce window so
// every step and press can be followed edge by edge.

module tb_led_pattern_driver;

   logic       CLK;
   logic       RESETn;
   logic       iBtnSpeed;
   logic       iBtnMode;
   logic [5:0] oLED;
   logic [1:0] oSpeed;
   logic [1:0] oMode;

   int total = 0;
   int bad   = 0;

   led_pattern_driver #(
      .CLK_HZ   (16),
      .LED_W    (6),
      .SPEED_N  (3),
      .COUNT_MAX(60),
      .DEB_CYC  (4)
   ) dut (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .iBtnSpeed(iBtnSpeed),
      .iBtnMode (iBtnMode),
      .oLED     (oLED),
      .oSpeed   (oSpeed),
      .oMode    (oMode)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n active edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic logic [5:0] inv(input logic [5:0] p);
      return ~p;
   endfunction

   logic [5:0] chase_exp [6];
   int         bounce_pos [10];

   initial begin
      chase_exp  = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1};
      bounce_pos = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};

      RESETn    = 1'b1;
      iBtnSpeed = 1'b0;
      iBtnMode  = 1'b0;
      #2 RESETn = 1'b0;
      tick(2);
      check("rst_led",   32'(oLED),   32'h3F);
      check("rst_speed", 32'(oSpeed), 32'd0);
      check("rst_mode",  32'(oMode),  32'd0);

      RESETn = 1'b1;
      tick(79);
      check("cnt_4", 32'(oLED), 32'(inv(6'd4)));
      tick(1);
      check("cnt_5", 32'(oLED), 32'h3A);

      for (int p = 6; p <= 60; p++) begin
         tick(16);
         check("cnt_step", 32'(oLED), 32'(inv(6'(p))));
      end
      check("cnt_60", 32'(oLED), 32'h03);
      tick(16);
      check("cnt_wrap", 32'(oLED), 32'h3F);

      // Short glitch, then a long press of the speed button.
      iBtnSpeed = 1'b1;
      tick(2);
      iBtnSpeed = 1'b0;
      tick(10);
      check("glitch_speed", 32'(oSpeed), 32'd0);
      iBtnSpeed = 1'b1;
      tick(6);
      check("spd_early", 32'(oSpeed), 32'd0);
      tick(1);
      check("spd_latency", 32'(oSpeed), 32'd1);
      check("spd_led", 32'(oLED), 32'(inv(6'd1)));
      tick(7);
      check("p8_hold", 32'(oLED), 32'(inv(6'd1)));
      tick(1);
      check("p8_step", 32'(oLED), 32'(inv(6'd2)));
      tick(5);
      iBtnSpeed = 1'b0;
      tick(12);
      check("spd_held_once", 32'(oSpeed), 32'd1);
      check("spd_led_4", 32'(oLED), 32'(inv(6'd4)));

      // This press lands on the edge where a step was due; the step is dropped.
      iBtnSpeed = 1'b1;
      tick(7);
      check("spd_2", 32'(oSpeed), 32'd2);
      check("pulse_beats_step", 32'(oLED), 32'(inv(6'd4)));
      tick(3);
      check("p4_hold", 32'(oLED), 32'(inv(6'd4)));
      tick(1);
      check("p4_step", 32'(oLED), 32'(inv(6'd5)));
      iBtnSpeed = 1'b0;
      tick(10);
      iBtnSpeed = 1'b1;
      tick(7);
      check("spd_wrap", 32'(oSpeed), 32'd0);
      check("spd_wrap_led", 32'(oLED), 32'(inv(6'd9)));
      iBtnSpeed = 1'b0;
      tick(10);

      iBtnMode = 1'b1;
      tick(7);
      check("mode_1", 32'(oMode), 32'd1);
      check("chase_init", 32'(oLED), 32'h3E);
      iBtnMode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(16);
         check("chase_step", 32'(oLED), 32'(inv(chase_exp[i])));
      end

      iBtnMode = 1'b1;
      tick(7);
      check("mode_2", 32'(oMode), 32'd2);
      check("bounce_init", 32'(oLED), 32'(inv(6'd1)));
      iBtnMode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         logic [5:0] onehot;
         onehot = 6'd1 << bounce_pos[i];
         tick(16);
         check("bounce_step", 32'(oLED), 32'(inv(onehot)));
      end

      iBtnSpeed = 1'b1;
      iBtnMode  = 1'b1;
      tick(7);
      check("both_speed", 32'(oSpeed), 32'd1);
      check("both_mode",  32'(oMode),  32'd3);
      check("blink_init", 32'(oLED),   32'h3F);
      iBtnSpeed = 1'b0;
      iBtnMode  = 1'b0;
      tick(7);
      check("blink_hold", 32'(oLED), 32'h3F);
      tick(1);
      check("blink_step", 32'(oLED), 32'h00);

      tick(3);
      #3 RESETn = 1'b0;
      #1;
      check("arst_led",   32'(oLED),   32'h3F);
      check("arst_speed", 32'(oSpeed), 32'd0);
      check("arst_mode",  32'(oMode),  32'd0);
      #2 RESETn = 1'b1;
      tick(16);
      check("post_rst_1", 32'(oLED), 32'(inv(6'd1)));
      tick(16);
      check("post_rst_2", 32'(oLED), 32'(inv(6'd2)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
